// File: rtl/imem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter_if
//
// Bundles every signal shared between the instruction-memory port arbiter and
// the blocks around it:
//   fetch port  : if_req_i, if_addr_i -> if_gnt_o, if_rvalid_o, if_rdata_o
//   loader port : ld_req_i, ld_addr_i, ld_be_i, ld_wdata_i -> ld_gnt_o
//   sequencing  : boot_done_i -> run_o
//   memory side : mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o <- mem_rdata_i
//
// Signal names keep their _i/_o suffixes as seen from the arbiter.
// The arbiter connects through the 'slave' modport. The surrounding system
// (requesters plus memory) connects through 'master'.
// ---------------------------------------------------------------------------
interface imem_port_arbiter_if #(
    parameter int IMEM_W = 14,
    parameter int W      = 32
);
    // Fetch port
    logic              if_req_i;
    logic [IMEM_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [W-1:0]      if_rdata_o;

    // Loader port
    logic              ld_req_i;
    logic [IMEM_W-1:0] ld_addr_i;
    logic [3:0]        ld_be_i;
    logic [W-1:0]      ld_wdata_i;
    logic              ld_gnt_o;

    // Boot / run sequencing
    logic              boot_done_i;
    logic              run_o;

    // Memory side
    logic [IMEM_W-3:0] mem_addr_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [W-1:0]      mem_wdata_o;
    logic [W-1:0]      mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ld_req_i, ld_addr_i, ld_be_i, ld_wdata_i,
        output ld_gnt_o,
        input  boot_done_i,
        output run_o,
        output mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ld_req_i, ld_addr_i, ld_be_i, ld_wdata_i,
        input  ld_gnt_o,
        output boot_done_i,
        input  run_o,
        input  mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares one single-port instruction memory between two requesters:
//   - the core instruction-fetch port (reads)
//   - the boot/program loader (byte-masked writes)
//
// After reset the block is in BOOT. In BOOT only the loader is served. A
// boot_done_i pulse moves it to RUN. In RUN both requesters compete
// round-robin. Only reset returns the block to BOOT.
//
// Grants and memory controls are combinational from the current requests.
// The memory has a registered read. A fetch granted in cycle N therefore sees
// its data on mem_rdata_i in cycle N+1. That is also the cycle in which
// if_rvalid_o is high.
//
// Ports:
//   clk_i   : clock. All state changes on the rising edge.
//   rst_ni  : asynchronous active-low reset.
//   bus     : imem_port_arbiter_if.slave, which carries the fetch, loader,
//             boot sequencing and memory-side signals.
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int IMEM_W = 14,
    parameter int W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    imem_port_arbiter_if.slave   bus
);
    localparam int AW = IMEM_W - 2;   // word-index width

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_reg,   state_next;
    logic           last_ld_reg, last_ld_next;   // 1: loader granted most recently
    logic [AW-1:0]  addr_reg,    addr_next;
    logic           rvalid_reg;
    logic [W-1:0]   rdata_reg,   rdata_next;

    logic           if_gnt;
    logic           ld_gnt;
    logic [3:0]     be_lane;

    // Byte-offset bits of both addresses are ignored by design.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr_i[1:0], bus.ld_addr_i[1:0]};

    // -----------------------------------------------------------------------
    // State register, last-grant pointer, held address, read pipeline
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_BOOT;
            last_ld_reg <= 1'b1;
            addr_reg    <= '0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            last_ld_reg <= last_ld_next;
            addr_reg    <= addr_next;
            rvalid_reg  <= if_gnt;
            rdata_reg   <= rdata_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and grant arbitration
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if_gnt     = 1'b0;
        ld_gnt     = 1'b0;

        // The grants stay low while reset is held. This way the memory never
        // sees a write strobe, and the reset-state outputs hold, even if
        // requesters keep their req lines high.
        if (rst_ni) begin
            case (state_reg)
                ST_BOOT: begin
                    // A loader write in the boot_done_i cycle still goes through.
                    ld_gnt = bus.ld_req_i;
                    if (bus.boot_done_i) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.if_req_i && bus.ld_req_i) begin
                        // Contention: the side that did not win last time wins.
                        if (last_ld_reg) begin
                            if_gnt = 1'b1;
                        end else begin
                            ld_gnt = 1'b1;
                        end
                    end else begin
                        if_gnt = bus.if_req_i;
                        ld_gnt = bus.ld_req_i;
                    end
                end
                default: begin
                    state_next = ST_BOOT;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Pointer / address / read data next-values
    // -----------------------------------------------------------------------
    always_comb begin
        last_ld_next = last_ld_reg;
        addr_next    = addr_reg;
        if (ld_gnt) begin
            last_ld_next = 1'b1;
            addr_next    = bus.ld_addr_i[IMEM_W-1:2];
        end else if (if_gnt) begin
            last_ld_next = 1'b0;
            addr_next    = bus.if_addr_i[IMEM_W-1:2];
        end
    end

    // The memory presents read data in the rvalid cycle. Pass it straight
    // through then, and hold the last returned word at all other times.
    always_comb begin
        rdata_next = rdata_reg;
        if (rvalid_reg) begin
            rdata_next = bus.mem_rdata_i;
        end
    end

    // -----------------------------------------------------------------------
    // Byte enables are driven only on a granted write
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_lane
            assign be_lane[gi] = ld_gnt & bus.ld_be_i[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.if_gnt_o    = if_gnt;
    assign bus.ld_gnt_o    = ld_gnt;
    assign bus.run_o       = (state_reg == ST_RUN);
    assign bus.if_rvalid_o = rvalid_reg;
    assign bus.if_rdata_o  = rdata_next;

    // The address follows a grant at once and otherwise holds its last value.
    assign bus.mem_addr_o  = addr_next;
    assign bus.mem_we_o    = ld_gnt;
    assign bus.mem_be_o    = be_lane;
    assign bus.mem_wdata_o = ld_gnt ? bus.ld_wdata_i : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Directed testbench. A table of per-cycle vectors takes the arbiter through
// the following sequence:
//   - BOOT with a blocked fetch
//   - the boot load
//   - fetch latency
//   - round-robin contention
//   - a byte-masked write at the top address
//   - read-after-write
//   - a write with no byte lanes enabled
//   - boot_done_i ignored in RUN
// A hand-written sequence then covers the asynchronous reset mid-fetch.
// A small synchronous memory model with a registered read sits on the
// memory side.
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;
    localparam int IMEM_W = 14;
    localparam int W      = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.IMEM_W(IMEM_W), .W(W)) bus ();

    imem_port_arbiter #(.IMEM_W(IMEM_W), .W(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Memory model: byte-masked write on the edge, registered read.
    logic [31:0] mem [0:4095];
    logic [31:0] mem_rdata_q = '0;
    assign bus.mem_rdata_i = mem_rdata_q;

    always @(posedge clk) begin
        if (bus.mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_be_o[b]) mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            end
        end
        mem_rdata_q <= mem[bus.mem_addr_o];
    end

    typedef struct {
        logic        ld_req;
        logic [13:0] ld_addr;
        logic [3:0]  ld_be;
        logic [31:0] ld_wdata;
        logic        if_req;
        logic [13:0] if_addr;
        logic        boot_done;
        logic        e_ld_gnt;
        logic        e_if_gnt;
        logic        e_we;
        logic [3:0]  e_be;
        logic [11:0] e_addr;
        logic        e_run;
        logic        e_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ld_req, input logic [13:0] ld_addr, input logic [3:0] ld_be,
        input logic [31:0] ld_wdata, input logic if_req, input logic [13:0] if_addr,
        input logic boot_done, input logic e_ld_gnt, input logic e_if_gnt,
        input logic e_we, input logic [3:0] e_be, input logic [11:0] e_addr,
        input logic e_run, input logic e_rvalid, input logic [31:0] e_rdata);
        vec_t v;
        v.ld_req = ld_req;     v.ld_addr = ld_addr;   v.ld_be = ld_be;
        v.ld_wdata = ld_wdata; v.if_req = if_req;     v.if_addr = if_addr;
        v.boot_done = boot_done;
        v.e_ld_gnt = e_ld_gnt; v.e_if_gnt = e_if_gnt; v.e_we = e_we;
        v.e_be = e_be;         v.e_addr = e_addr;     v.e_run = e_run;
        v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic drive_idle();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.ld_req_i    = 1'b0;
        bus.ld_addr_i   = '0;
        bus.ld_be_i     = '0;
        bus.ld_wdata_i  = '0;
        bus.boot_done_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        //            ld  ld_addr  be    wdata          if  if_addr  bd | ldg ifg we be    addr    run rv  rdata
        vecs[0]  = mk(0, 14'h000, 4'h0, 32'h0,        1, 14'h010, 0,  0,  0,  0, 4'h0, 12'h000, 0, 0, 32'h0);
        vecs[1]  = mk(0, 14'h000, 4'h0, 32'h0,        1, 14'h010, 0,  0,  0,  0, 4'h0, 12'h000, 0, 0, 32'h0);
        vecs[2]  = mk(0, 14'h000, 4'h0, 32'h0,        1, 14'h010, 0,  0,  0,  0, 4'h0, 12'h000, 0, 0, 32'h0);
        vecs[3]  = mk(1, 14'h000, 4'hF, 32'h00000013, 0, 14'h000, 0,  1,  0,  1, 4'hF, 12'h000, 0, 0, 32'h0);
        vecs[4]  = mk(1, 14'h004, 4'hF, 32'h00100093, 0, 14'h000, 0,  1,  0,  1, 4'hF, 12'h001, 0, 0, 32'h0);
        vecs[5]  = mk(1, 14'h008, 4'hF, 32'hDEADBEEF, 0, 14'h000, 1,  1,  0,  1, 4'hF, 12'h002, 0, 0, 32'h0);
        vecs[6]  = mk(0, 14'h000, 4'h0, 32'h0,        0, 14'h000, 0,  0,  0,  0, 4'h0, 12'h002, 1, 0, 32'h0);
        vecs[7]  = mk(0, 14'h000, 4'h0, 32'h0,        1, 14'h008, 0,  0,  1,  0, 4'h0, 12'h002, 1, 0, 32'h0);
        vecs[8]  = mk(0, 14'h000, 4'h0, 32'h0,        0, 14'h000, 0,  0,  0,  0, 4'h0, 12'h002, 1, 1, 32'hDEADBEEF);
        vecs[9]  = mk(0, 14'h000, 4'h0, 32'h0,        0, 14'h000, 0,  0,  0,  0, 4'h0, 12'h002, 1, 0, 32'hDEADBEEF);
        vecs[10] = mk(1, 14'h00C, 4'hF, 32'h11223344, 0, 14'h000, 0,  1,  0,  1, 4'hF, 12'h003, 1, 0, 32'hDEADBEEF);
        vecs[11] = mk(1, 14'h010, 4'hF, 32'h55667788, 1, 14'h000, 0,  0,  1,  0, 4'h0, 12'h000, 1, 0, 32'hDEADBEEF);
        vecs[12] = mk(1, 14'h010, 4'hF, 32'h55667788, 1, 14'h004, 0,  1,  0,  1, 4'hF, 12'h004, 1, 1, 32'h00000013);
        vecs[13] = mk(1, 14'h014, 4'hF, 32'h99AABBCC, 1, 14'h004, 0,  0,  1,  0, 4'h0, 12'h001, 1, 0, 32'h00000013);
        vecs[14] = mk(1, 14'h014, 4'hF, 32'h99AABBCC, 1, 14'h008, 0,  1,  0,  1, 4'hF, 12'h005, 1, 1, 32'h00100093);
        vecs[15] = mk(0, 14'h000, 4'h0, 32'h0,        1, 14'h008, 0,  0,  1,  0, 4'h0, 12'h002, 1, 0, 32'h00100093);
        vecs[16] = mk(1, 14'h3FFE,4'h3, 32'hAAAA5555, 0, 14'h000, 0,  1,  0,  1, 4'h3, 12'hFFF, 1, 1, 32'hDEADBEEF);
        vecs[17] = mk(0, 14'h000, 4'h0, 32'h0,        1, 14'h3FFC,0,  0,  1,  0, 4'h0, 12'hFFF, 1, 0, 32'hDEADBEEF);
        vecs[18] = mk(1, 14'h008, 4'h0, 32'hFFFFFFFF, 0, 14'h000, 0,  1,  0,  1, 4'h0, 12'h002, 1, 1, 32'h00005555);
        vecs[19] = mk(0, 14'h000, 4'h0, 32'h0,        1, 14'h008, 0,  0,  1,  0, 4'h0, 12'h002, 1, 0, 32'h00005555);
        vecs[20] = mk(0, 14'h000, 4'h0, 32'h0,        0, 14'h000, 1,  0,  0,  0, 4'h0, 12'h002, 1, 1, 32'hDEADBEEF);
        vecs[21] = mk(0, 14'h000, 4'h0, 32'h0,        0, 14'h000, 0,  0,  0,  0, 4'h0, 12'h002, 1, 0, 32'hDEADBEEF);

        // Reset held, loader requesting: no strobe, reset-state outputs.
        drive_idle();
        bus.ld_req_i  = 1'b1;
        bus.ld_be_i   = 4'hF;
        bus.ld_addr_i = 14'h0040;
        #1;
        chk("rst ld_gnt",  {31'b0, bus.ld_gnt_o},    32'h0);
        chk("rst we",      {31'b0, bus.mem_we_o},    32'h0);
        chk("rst be",      {28'b0, bus.mem_be_o},    32'h0);
        chk("rst addr",    {20'b0, bus.mem_addr_o},  32'h0);
        chk("rst run",     {31'b0, bus.run_o},       32'h0);
        chk("rst rvalid",  {31'b0, bus.if_rvalid_o}, 32'h0);
        chk("rst rdata",   bus.if_rdata_o,           32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.ld_req_i    = vecs[i].ld_req;
            bus.ld_addr_i   = vecs[i].ld_addr;
            bus.ld_be_i     = vecs[i].ld_be;
            bus.ld_wdata_i  = vecs[i].ld_wdata;
            bus.if_req_i    = vecs[i].if_req;
            bus.if_addr_i   = vecs[i].if_addr;
            bus.boot_done_i = vecs[i].boot_done;
            #1;
            $display("vec %0d: ld_gnt=%0b if_gnt=%0b we=%0b be=%h addr=%h run=%0b rvalid=%0b rdata=%h",
                     i, bus.ld_gnt_o, bus.if_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
                     bus.run_o, bus.if_rvalid_o, bus.if_rdata_o);
            chk($sformatf("v%0d ld_gnt", i), {31'b0, bus.ld_gnt_o},    {31'b0, vecs[i].e_ld_gnt});
            chk($sformatf("v%0d if_gnt", i), {31'b0, bus.if_gnt_o},    {31'b0, vecs[i].e_if_gnt});
            chk($sformatf("v%0d we", i),     {31'b0, bus.mem_we_o},    {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d be", i),     {28'b0, bus.mem_be_o},    {28'b0, vecs[i].e_be});
            chk($sformatf("v%0d addr", i),   {20'b0, bus.mem_addr_o},  {20'b0, vecs[i].e_addr});
            chk($sformatf("v%0d run", i),    {31'b0, bus.run_o},       {31'b0, vecs[i].e_run});
            chk($sformatf("v%0d rvalid", i), {31'b0, bus.if_rvalid_o}, {31'b0, vecs[i].e_rvalid});
            chk($sformatf("v%0d rdata", i),  bus.if_rdata_o,           vecs[i].e_rdata);
            if (vecs[i].e_we) chk($sformatf("v%0d wdata", i), bus.mem_wdata_o, vecs[i].ld_wdata);
        end

        // Asynchronous reset half a cycle after a fetch grant.
        @(negedge clk);
        drive_idle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 14'h008;
        #1;
        chk("arst pre if_gnt", {31'b0, bus.if_gnt_o}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        $display("arst: run=%0b rvalid=%0b we=%0b addr=%h rdata=%h",
                 bus.run_o, bus.if_rvalid_o, bus.mem_we_o, bus.mem_addr_o, bus.if_rdata_o);
        chk("arst run",    {31'b0, bus.run_o},       32'h0);
        chk("arst if_gnt", {31'b0, bus.if_gnt_o},    32'h0);
        chk("arst rvalid", {31'b0, bus.if_rvalid_o}, 32'h0);
        chk("arst addr",   {20'b0, bus.mem_addr_o},  32'h0);
        chk("arst rdata",  bus.if_rdata_o,           32'h0);
        @(posedge clk);
        #1;
        chk("arst edge rvalid", {31'b0, bus.if_rvalid_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst if_gnt 0", {31'b0, bus.if_gnt_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("post rst if_gnt 1", {31'b0, bus.if_gnt_o},    32'h0);
        chk("post rst rvalid",   {31'b0, bus.if_rvalid_o}, 32'h0);
        chk("post rst run",      {31'b0, bus.run_o},       32'h0);
        bus.boot_done_i = 1'b1;
        #1;
        chk("boot_done cycle if_gnt", {31'b0, bus.if_gnt_o}, 32'h0);
        @(negedge clk);
        bus.boot_done_i = 1'b0;
        #1;
        chk("rerun run",    {31'b0, bus.run_o},      32'h1);
        chk("rerun if_gnt", {31'b0, bus.if_gnt_o},   32'h1);
        chk("rerun addr",   {20'b0, bus.mem_addr_o}, 32'h2);
        @(negedge clk);
        bus.if_req_i = 1'b0;
        #1;
        $display("rerun fetch: rvalid=%0b rdata=%h", bus.if_rvalid_o, bus.if_rdata_o);
        chk("rerun rvalid", {31'b0, bus.if_rvalid_o}, 32'h1);
        chk("rerun rdata",  bus.if_rdata_o,           32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
